// File: rtl/serial_twos_complementer_if.sv
// Bus bundle for the serial two's complementer.
//   start    requester -> converter  request to convert din
//   din      requester -> converter  two's-complement operand, taken when start is accepted
//   busy     converter -> requester  conversion in progress, start ignored while high
//   done     converter -> requester  one-cycle pulse, dout/overflow freshly valid
//   dout     converter -> requester  -din mod 2^WIDTH, held until the next completion
//   overflow converter -> requester  operand was the most-negative value
`timescale 1ns / 1ps

interface serial_twos_complementer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             overflow;

  // Requester side (drives the request, observes the result).
  modport master (
    output start,
    output din,
    input  busy,
    input  done,
    input  dout,
    input  overflow
  );

  // Converter side.
  modport slave (
    input  start,
    input  din,
    output busy,
    output done,
    output dout,
    output overflow
  );
endinterface

// File: rtl/serial_twos_complementer.sv
// Bit-serial two's-complement negator.
// A start in idle loads din; the operand is then streamed LSB first through a single
// full-adder slice computing ~bit + carry (carry seeded with 1), so after WIDTH cycles the
// result register holds ~din + 1 = -din mod 2^WIDTH. A one-cycle done pulse follows, after
// which the unit returns to idle. dout/overflow are registered and only change on completion.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset, aborts any conversion in flight
//   bus    serial_twos_complementer_if slave modport (start/din in, busy/done/dout/overflow out)
`timescale 1ns / 1ps

module serial_twos_complementer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_twos_complementer_if.slave     bus
);

  // Counter must also hold WIDTH itself (value after the final shift increment).
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_twos_complementer: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             carry_q, carry_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             overflow_q, overflow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // One full-adder slice: A = inverted operand bit, B tied low, Cin = running carry.
  logic             slice_a;
  logic             slice_b;
  logic             slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] result_shifted;
  logic             last_bit;

  assign slice_a    = ~operand_q[0];
  assign slice_b    = 1'b0;
  assign slice_sum  = slice_a ^ slice_b ^ carry_q;
  assign slice_cout = (slice_a & slice_b) | (slice_a & carry_q) | (slice_b & carry_q);

  // Sum enters at the MSB so the first (LSB) sum bit lands in bit 0 after WIDTH shifts.
  assign result_shifted = {slice_sum, result_q[WIDTH-1:1]};
  assign last_bit       = (cnt_q == LastCnt);

  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    result_d   = result_q;
    dout_d     = dout_q;
    carry_d    = carry_q;
    ovf_pend_d = ovf_pend_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          operand_d  = bus.din;
          result_d   = '0;
          carry_d    = 1'b1;
          cnt_d      = '0;
          ovf_pend_d = (bus.din == MostNeg);
          state_d    = StShift;
        end
      end

      StShift: begin
        operand_d = {1'b0, operand_q[WIDTH-1:1]};
        result_d  = result_shifted;
        // Carry out of the MSB slice is simply dropped on the last step.
        carry_d   = slice_cout;
        cnt_d     = cnt_q + CntW'(1);
        if (last_bit) begin
          dout_d     = result_shifted;
          overflow_d = ovf_pend_q;
          state_d    = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      operand_q  <= '0;
      result_q   <= '0;
      dout_q     <= '0;
      carry_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      result_q   <= result_d;
      dout_q     <= dout_d;
      carry_q    <= carry_d;
      ovf_pend_q <= ovf_pend_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.dout     = dout_q;
  assign bus.overflow = overflow_q;

`ifndef SYNTHESIS
  done_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    bus.done |=> !bus.done);
  done_implies_busy: assert property (@(posedge clk) disable iff (!rst_n)
    bus.done |-> bus.busy);
`endif

endmodule

// File: doc/serial_twos_complementer.md
SERIAL_TWOS_COMPLEMENTER -- requirements
Module: serial_twos_complementer

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to convert din.
REQ-005 Port: din  input  WIDTH  two's-complement operand, sampled only when a start is accepted.
REQ-006 Port: busy  output  1  high while a conversion is in progress; start ignored while high.
REQ-007 Port: done  output  1  one-cycle pulse, dout/overflow valid.
REQ-008 Port: dout  output  WIDTH  negated operand (-din mod 2^WIDTH).
REQ-009 Port: overflow  output  1  high when din is the most-negative value (MSB 1, all other bits 0).

Function
REQ-010 The module SHALL be a 3-state FSM: IDLE, SHIFT, DONE.
REQ-011 In IDLE with start=1 at a rising edge, the module SHALL load din into an operand shift register, clear the result register, set the carry flop to 1, clear the bit counter, and go to SHIFT.
REQ-012 In IDLE with start=0, the module SHALL hold all registers.
REQ-013 In SHIFT, each edge SHALL process one operand bit, LSB first, through one full-adder slice: A = ~bit, B = 0, Cin = carry; sum shifts into the result register MSB-side; carry <= Cout.
REQ-014 The bit counter SHALL increment once per SHIFT edge; after exactly WIDTH SHIFT edges the FSM SHALL go to DONE.
REQ-015 In DONE the module SHALL drive done=1 for exactly one cycle, then go to IDLE on the next edge.
REQ-016 Latency: with start accepted at edge N, done SHALL be high in the cycle following edge N+WIDTH.
REQ-017 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-018 start SHALL be ignored in SHIFT and DONE; it is not queued.
REQ-019 dout SHALL update only when entering DONE, then hold until the next conversion completes.
REQ-020 overflow SHALL be computed from din at load, update with dout when entering DONE, and hold with it.
REQ-021 Final carry out of the MSB slice SHALL be discarded; result is modulo 2^WIDTH.
REQ-022 din = 0 SHALL produce dout = 0, overflow = 0.
REQ-023 Back-to-back operation: start held high SHALL give one conversion every WIDTH+2 cycles.

Reset
REQ-024 rst_n low SHALL immediately, without clk, force IDLE; busy=0, done=0, dout=0, overflow=0; clear counter, shift, result and carry registers.
REQ-025 Reset asserted during SHIFT or DONE SHALL abort the conversion; done SHALL not pulse for the aborted operation.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where rst_n is high and start=1.

Verification (WIDTH=8)
REQ-027 start with din=0x05 -> done 8 cycles after the accept edge (after edge N+8); dout=0xFB, overflow=0; busy high for 9 cycles.
REQ-028 din=0xFF -> dout=0x01, overflow=0; din=0x00 -> dout=0x00, overflow=0.
REQ-029 din=0x80 -> dout=0x80, overflow=1; next conversion din=0x7F -> dout=0x81, overflow=0.
REQ-030 start pulsed with din=0x33 in the 3rd SHIFT cycle of a 0x05 conversion -> ignored; dout=0xFB, only one done pulse.
REQ-031 rst_n low for 1 cycle mid-SHIFT -> outputs 0 at once, no done; then start with din=0x01 -> dout=0xFF.
REQ-032 start held high for 30 cycles with din=0x02 -> done at 10-cycle spacing, dout=0xFE each time.
